// File: rtl/net_axis_frame_tx.sv
// -----------------------------------------------------------------------------
// net_axis_frame_tx
// Buffers words in a small synchronous FIFO and sends them as fixed-length
// AXI-Stream frames. A frame is started with a one-cycle start pulse. Its
// length comes from cfg_frame_len, and 0 selects C_NET_CELL_COUNT*9+2 beats.
// The last beat carries tlast. Once that beat is accepted, frame_done pulses
// for one cycle.
//
// Optional feature (compile-time macro NET_TX_ZERO_PAD_EN):
//   When the macro is defined and the FIFO runs empty mid-frame, zero pad beats
//   are sent. These beats count toward the frame length.
//   When the macro is undefined, tvalid drops and the frame stalls until more
//   words arrive.
//
// Ports:
//   m00_axis_aclk    in   clock (rising edge)
//   m00_axis_areset  in   synchronous active-high reset
//   push, push_data  in   write one word into the FIFO (dropped when full)
//   full             out  FIFO holds C_FIFO_DEPTH words
//   start            in   one-cycle frame request (honoured only when idle)
//   cfg_frame_len    in   beats per frame, 0 = default length
//   busy             out  frame in progress (STREAM or DONE)
//   frame_done       out  one-cycle pulse after the tlast beat is accepted
//   m00_axis_t*      out  AXI-Stream master: tvalid/tdata/tstrb/tlast
//   m00_axis_tready  in   downstream ready
// -----------------------------------------------------------------------------
module net_axis_frame_tx #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH           = 16,
  parameter int C_NET_CELL_COUNT       = 100
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_areset,
  input  logic                                push,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   push_data,
  output logic                                full,
  input  logic                                start,
  input  logic [15:0]                         cfg_frame_len,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready
);

  localparam int          C_W           = C_M00_AXIS_TDATA_WIDTH;
  localparam int          C_AW          = $clog2(C_FIFO_DEPTH);
  localparam logic [15:0] C_DEFAULT_LEN = 16'(C_NET_CELL_COUNT * 9 + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  // FIFO storage and bookkeeping
  logic [C_W-1:0]  r_mem [C_FIFO_DEPTH];
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW:0]   r_count;

  // Frame control
  state_t          r_state;
  logic [15:0]     r_len;
  logic [15:0]     r_beat_cnt;
  logic            r_busy;
  logic            r_frame_done;

  logic            w_empty;
  logic            w_full;
  logic            w_push_ok;
  logic            w_pad;
  logic            w_tvalid;
  logic            w_accept;
  logic            w_pop;
  logic            w_last_beat;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (C_AW + 1)'(C_FIFO_DEPTH));
  assign w_push_ok = push && !w_full;

`ifdef NET_TX_ZERO_PAD_EN
  // A pad beat that has been offered but not yet taken keeps being offered,
  // even if a word is pushed meanwhile. Without this, tdata would change
  // from 0 to the new word while tvalid is high and tready is low.
  logic r_pad_hold;

  assign w_pad = (r_state == S_STREAM) && (w_empty || r_pad_hold);

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      r_pad_hold <= 1'b0;
    end else begin
      r_pad_hold <= w_pad && !m00_axis_tready;
    end
  end
`else
  assign w_pad = 1'b0;
`endif

  // tvalid follows FIFO occupancy directly, so the head word is presented
  // with no extra latency. Stability while stalled comes for free: the head
  // word only changes on a pop, and a pop needs tready.
  assign w_tvalid    = (r_state == S_STREAM) && (!w_empty || w_pad);
  assign w_accept    = w_tvalid && m00_axis_tready;
  assign w_pop       = w_accept && !w_pad;
  assign w_last_beat = (r_beat_cnt == r_len - 16'd1);

  assign m00_axis_tvalid = w_tvalid;
  assign m00_axis_tdata  = (w_tvalid && !w_pad) ? r_mem[r_rd_ptr] : '0;
  assign m00_axis_tstrb  = {(C_W / 8){w_tvalid}};
  assign m00_axis_tlast  = w_tvalid && w_last_beat;
  assign full            = w_full;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;

  // FIFO storage has no reset, so it can map onto memory primitives.
  always_ff @(posedge m00_axis_aclk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (C_AW + 1)'(1);
        2'b01:   r_count <= r_count - (C_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM. busy and frame_done are registered alongside the state.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len      <= (cfg_frame_len == 16'd0) ? C_DEFAULT_LEN : cfg_frame_len;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
            if (w_last_beat) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
